// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory stage controller for a Y86-64 style core.
// Decodes the memory opcode and issues a single request on a
// valid/ready request channel. It then waits, with a bounded timeout,
// for the matching response on the response channel.
module mem_access_ctrl #(
    parameter logic [63:0] ADDR_LIMIT = 64'd1025,
    parameter int          TIMEOUT    = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_icode,
    input  logic [63:0] i_valA,
    input  logic [63:0] i_valE,
    input  logic [63:0] i_valP,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_valM,
    output logic        o_mem_err,
    output logic        o_req_valid,
    output logic        o_req_we,
    output logic [63:0] o_req_addr,
    output logic [63:0] o_req_wdata,
    input  logic        i_req_ready,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_err,
    input  logic [63:0] i_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [4:0] LP_TIMEOUT = 5'(TIMEOUT);

    localparam logic [3:0] OP_RMMOVQ = 4'h4;
    localparam logic [3:0] OP_MRMOVQ = 4'h5;
    localparam logic [3:0] OP_CALL   = 4'h8;
    localparam logic [3:0] OP_RET    = 4'h9;
    localparam logic [3:0] OP_PUSHQ  = 4'hA;
    localparam logic [3:0] OP_POPQ   = 4'hB;

    state_t      r_state;
    logic [3:0]  r_icode;
    logic [3:0]  r_wait_cnt;

    logic        w_is_mem;
    logic        w_is_write;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic        w_in_range;
    logic        w_lat_write;
    logic [4:0]  w_cnt_inc;
    logic        w_timeout;

    // Stores write to memory; loads read. Decoding the latched icode
    // later tells WAIT whether the response data belongs in valM.
    function automatic logic isWriteOp(input logic [3:0] op);
        return (op == OP_RMMOVQ) || (op == OP_CALL) || (op == OP_PUSHQ);
    endfunction

    // Decode the incoming opcode into direction, address and write data.
    // Pops and returns address through the old stack pointer in valA.
    always_comb begin
        w_is_mem   = 1'b0;
        w_is_write = 1'b0;
        w_addr     = i_valE;
        w_wdata    = i_valA;
        case (i_icode)
            OP_RMMOVQ: begin w_is_mem = 1'b1; w_is_write = 1'b1; end
            OP_MRMOVQ: begin w_is_mem = 1'b1; end
            OP_CALL:   begin w_is_mem = 1'b1; w_is_write = 1'b1; w_wdata = i_valP; end
            OP_RET:    begin w_is_mem = 1'b1; w_addr = i_valA; end
            OP_PUSHQ:  begin w_is_mem = 1'b1; w_is_write = 1'b1; end
            OP_POPQ:   begin w_is_mem = 1'b1; w_addr = i_valA; end
            default:   begin w_is_mem = 1'b0; end
        endcase
    end

    // Range check and the timeout compare. The 4-bit counter is widened
    // so that the increment cannot wrap before the compare.
    always_comb begin
        w_in_range  = (w_addr < ADDR_LIMIT);
        w_lat_write = isWriteOp(r_icode);
        w_cnt_inc   = {1'b0, r_wait_cnt} + 5'd1;
        w_timeout   = (w_cnt_inc >= LP_TIMEOUT);
    end

    // Controller FSM. All outputs are registered here alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_icode     <= 4'h0;
            r_wait_cnt  <= 4'h0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_valM      <= 64'h0;
            o_mem_err   <= 1'b0;
            o_req_valid <= 1'b0;
            o_req_we    <= 1'b0;
            o_req_addr  <= 64'h0;
            o_req_wdata <= 64'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_icode <= i_icode;
                        o_busy  <= 1'b1;
                        if (w_is_mem && w_in_range) begin
                            r_state     <= S_REQ;
                            o_req_valid <= 1'b1;
                            o_req_we    <= w_is_write;
                            o_req_addr  <= w_addr;
                            o_req_wdata <= w_wdata;
                            o_mem_err   <= 1'b0;
                        end else begin
                            r_state   <= S_DONE;
                            o_done    <= 1'b1;
                            o_mem_err <= w_is_mem;
                        end
                    end
                end
                S_REQ: begin
                    if (i_req_ready) begin
                        r_state     <= S_WAIT;
                        o_req_valid <= 1'b0;
                        r_wait_cnt  <= 4'h0;
                    end
                end
                S_WAIT: begin
                    if (i_rsp_valid) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_mem_err <= i_rsp_err;
                        if (!w_lat_write && !i_rsp_err) begin
                            o_valM <= i_rsp_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_mem_err <= 1'b1;
                    end else if (r_wait_cnt != 4'hF) begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_done      <= 1'b0;
                    o_busy      <= 1'b0;
                    o_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed, table-driven bench for mem_access_ctrl,
// plus hand-written sequences for stalls, timeout, busy-start and reset.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        busy, done, memErr;
    logic [63:0] valM;
    logic        reqValid, reqWe;
    logic [63:0] reqAddr, reqWdata;
    logic        reqReady, rspValid, rspErr;
    logic [63:0] rspRdata;

    int nCompared   = 0;
    int nMismatched = 0;

    mem_access_ctrl #(.ADDR_LIMIT(64'd1025), .TIMEOUT(15)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_icode     (icode),
        .i_valA      (valA),
        .i_valE      (valE),
        .i_valP      (valP),
        .o_busy      (busy),
        .o_done      (done),
        .o_valM      (valM),
        .o_mem_err   (memErr),
        .o_req_valid (reqValid),
        .o_req_we    (reqWe),
        .o_req_addr  (reqAddr),
        .o_req_wdata (reqWdata),
        .i_req_ready (reqReady),
        .i_rsp_valid (rspValid),
        .i_rsp_err   (rspErr),
        .i_rsp_rdata (rspRdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valA;
        logic [63:0] valE;
        logic [63:0] valP;
        logic        rspErr;
        logic [63:0] rdata;
        logic        expBus;
        logic        expWe;
        logic [63:0] expAddr;
        logic [63:0] expWdata;
        int          expDone;
        logic        expErr;
        logic [63:0] expValM;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mkVec(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] e, input logic [63:0] p,
                                   input logic re, input logic [63:0] rd,
                                   input logic bus, input logic we,
                                   input logic [63:0] addr, input logic [63:0] wd,
                                   input int dn, input logic err, input logic [63:0] vm);
        vec_t v;
        v.icode = op; v.valA = a; v.valE = e; v.valP = p;
        v.rspErr = re; v.rdata = rd; v.expBus = bus; v.expWe = we;
        v.expAddr = addr; v.expWdata = wd; v.expDone = dn;
        v.expErr = err; v.expValM = vm;
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one transaction with an always-ready memory that answers one
    // cycle after the handshake, then compare against the vector.
    task automatic applyStimulus(input vec_t v, input int idx);
        int c;
        int doneAt;
        bit hsPrev;
        bit seenBus;
        start = 1'b1; icode = v.icode; valA = v.valA; valE = v.valE; valP = v.valP;
        reqReady = 1'b1; rspValid = 1'b0; rspErr = v.rspErr; rspRdata = v.rdata;
        tick();
        start = 1'b0;
        c = 1; doneAt = -1; hsPrev = 1'b0; seenBus = 1'b0;
        while (c < 40 && doneAt < 0) begin
            if (reqValid && !seenBus) begin
                seenBus = 1'b1;
                checkOutput($sformatf("v%0d req_we", idx), 64'(reqWe), 64'(v.expWe));
                checkOutput($sformatf("v%0d req_addr", idx), reqAddr, v.expAddr);
                if (v.expWe)
                    checkOutput($sformatf("v%0d req_wdata", idx), reqWdata, v.expWdata);
            end
            if (done) begin
                doneAt = c;
            end else begin
                rspValid = hsPrev;
                hsPrev = reqValid;
                tick();
                c++;
            end
        end
        rspValid = 1'b0;
        checkOutput($sformatf("v%0d done_cycle", idx), 64'(doneAt), 64'(v.expDone));
        checkOutput($sformatf("v%0d bus_used", idx), 64'(seenBus), 64'(v.expBus));
        checkOutput($sformatf("v%0d mem_err", idx), 64'(memErr), 64'(v.expErr));
        checkOutput($sformatf("v%0d valM", idx), valM, v.expValM);
        tick();
        checkOutput($sformatf("v%0d done_drop", idx), 64'(done), 64'd0);
        checkOutput($sformatf("v%0d busy_drop", idx), 64'(busy), 64'd0);
    endtask

    // Bound the whole run in case the DUT stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        int c;
        int doneAt;
        bit sawDone;
        rst_n = 1'b1; start = 1'b0; icode = 4'h0;
        valA = 64'h0; valE = 64'h0; valP = 64'h0;
        reqReady = 1'b0; rspValid = 1'b0; rspErr = 1'b0; rspRdata = 64'h0;

        vecs[0]  = mkVec(4'h5, 64'h99,   64'd7,    64'h11, 1'b0, 64'd5,     1, 0, 64'd7,    64'h0,    3, 0, 64'd5);
        vecs[1]  = mkVec(4'h4, 64'hAAAA, 64'd16,   64'h22, 1'b0, 64'h0,     1, 1, 64'd16,   64'hAAAA, 3, 0, 64'd5);
        vecs[2]  = mkVec(4'h8, 64'h1,    64'h3F0,  64'h55, 1'b0, 64'h0,     1, 1, 64'h3F0,  64'h55,   3, 0, 64'd5);
        vecs[3]  = mkVec(4'h9, 64'd1024, 64'd3,    64'h0,  1'b0, 64'hDEAD,  1, 0, 64'd1024, 64'h0,    3, 0, 64'hDEAD);
        vecs[4]  = mkVec(4'hA, 64'h1,    64'd1025, 64'h0,  1'b0, 64'h0,     0, 0, 64'h0,    64'h0,    1, 1, 64'hDEAD);
        vecs[5]  = mkVec(4'hB, 64'd8,    64'd2,    64'h0,  1'b1, 64'hFFFF,  1, 0, 64'd8,    64'h0,    3, 1, 64'hDEAD);
        vecs[6]  = mkVec(4'hB, 64'd0,    64'd500,  64'h0,  1'b0, 64'h77,    1, 0, 64'd0,    64'h0,    3, 0, 64'h77);
        vecs[7]  = mkVec(4'h0, 64'h0,    64'd1,    64'h0,  1'b0, 64'h0,     0, 0, 64'h0,    64'h0,    1, 0, 64'h77);
        vecs[8]  = mkVec(4'h5, 64'd4,    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64'h0, 0, 0, 64'h0, 64'h0, 1, 1, 64'h77);
        vecs[9]  = mkVec(4'h4, 64'hBEEF, 64'd1024, 64'h0,  1'b0, 64'h1234,  1, 1, 64'd1024, 64'hBEEF, 3, 0, 64'h77);
        vecs[10] = mkVec(4'h7, 64'd5,    64'd5,    64'h0,  1'b0, 64'h0,     0, 0, 64'h0,    64'h0,    1, 0, 64'h77);

        // Asynchronous reset: outputs must clear without a clock edge.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst done", 64'(done), 64'd0);
        checkOutput("rst mem_err", 64'(memErr), 64'd0);
        checkOutput("rst req_valid", 64'(reqValid), 64'd0);
        checkOutput("rst req_we", 64'(reqWe), 64'd0);
        checkOutput("rst req_addr", reqAddr, 64'd0);
        checkOutput("rst req_wdata", reqWdata, 64'd0);
        checkOutput("rst valM", valM, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        // pushq with req_ready held low for three cycles; responses during
        // REQ and in the handshake cycle must be ignored, as must a start.
        start = 1'b1; icode = 4'hA; valE = 64'd100; valA = 64'h1234; valP = 64'd9;
        reqReady = 1'b0; rspValid = 1'b0; rspErr = 1'b0; rspRdata = 64'hABCD;
        tick();
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("stall c%0d req_valid", k), 64'(reqValid), 64'd1);
            checkOutput($sformatf("stall c%0d req_we", k), 64'(reqWe), 64'd1);
            checkOutput($sformatf("stall c%0d req_addr", k), reqAddr, 64'd100);
            checkOutput($sformatf("stall c%0d req_wdata", k), reqWdata, 64'h1234);
            reqReady = (k == 4);
            rspValid = 1'b1;
            start = (k == 2);
            icode = (k == 2) ? 4'h5 : 4'hA;
            valE = (k == 2) ? 64'd3 : 64'd100;
            tick();
        end
        start = 1'b0;
        checkOutput("stall wait req_valid", 64'(reqValid), 64'd0);
        checkOutput("stall handshake rsp ignored", 64'(done), 64'd0);
        rspValid = 1'b0;
        tick();
        checkOutput("stall wait done", 64'(done), 64'd0);
        rspValid = 1'b1;
        tick();
        rspValid = 1'b0;
        checkOutput("stall ack done", 64'(done), 64'd1);
        checkOutput("stall ack mem_err", 64'(memErr), 64'd0);
        checkOutput("stall ack valM", valM, 64'h77);
        tick();
        checkOutput("stall idle busy", 64'(busy), 64'd0);
        checkOutput("stall idle req_valid", 64'(reqValid), 64'd0);

        // call with no response: timeout after 15 WAIT cycles.
        start = 1'b1; icode = 4'h8; valE = 64'd200; valA = 64'h0; valP = 64'h40;
        reqReady = 1'b1; rspValid = 1'b0;
        tick();
        start = 1'b0;
        c = 1; doneAt = -1;
        while (c < 40 && doneAt < 0) begin
            if (done) doneAt = c;
            else begin tick(); c++; end
        end
        checkOutput("timeout done_cycle", 64'(doneAt), 64'd17);
        checkOutput("timeout mem_err", 64'(memErr), 64'd1);
        checkOutput("timeout valM", valM, 64'h77);
        tick();
        rspValid = 1'b1; rspErr = 1'b0; rspRdata = 64'h5555;
        tick();
        checkOutput("late rsp done", 64'(done), 64'd0);
        checkOutput("late rsp busy", 64'(busy), 64'd0);
        tick();
        rspValid = 1'b0;
        checkOutput("late rsp valM", valM, 64'h77);
        checkOutput("late rsp mem_err", 64'(memErr), 64'd1);

        // Non-memory opcode, then a start while busy in DONE.
        start = 1'b1; icode = 4'h6; valE = 64'd7;
        tick();
        checkOutput("nonmem done", 64'(done), 64'd1);
        checkOutput("nonmem busy", 64'(busy), 64'd1);
        checkOutput("nonmem mem_err", 64'(memErr), 64'd0);
        checkOutput("nonmem req_valid", 64'(reqValid), 64'd0);
        icode = 4'h5;
        tick();
        start = 1'b0;
        checkOutput("busy start busy", 64'(busy), 64'd0);
        checkOutput("busy start req_valid", 64'(reqValid), 64'd0);
        checkOutput("busy start done", 64'(done), 64'd0);

        // popq aborted by reset in WAIT; a later response is ignored.
        start = 1'b1; icode = 4'hB; valA = 64'd3; valE = 64'd9; reqReady = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("abort pre busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort mem_err", 64'(memErr), 64'd0);
        checkOutput("abort req_valid", 64'(reqValid), 64'd0);
        checkOutput("abort req_addr", reqAddr, 64'd0);
        checkOutput("abort valM", valM, 64'd0);
        rspValid = 1'b1; rspErr = 1'b0; rspRdata = 64'h9999;
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done || busy) sawDone = 1'b1;
        end
        rspValid = 1'b0;
        checkOutput("abort no activity", 64'(sawDone), 64'd0);
        checkOutput("abort late valM", valM, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_LIMIT, default 1025, SHALL be the number of valid 64-bit data-memory words; legal addresses are 0..ADDR_LIMIT-1.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of cycles spent in WAIT before an error is flagged.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL be a one-cycle request to run the memory stage for the current instruction.
REQ-006 icode  input  4  SHALL be the instruction code.
REQ-007 valA, valE, valP  input  64 each  SHALL be the operand, computed-address and next-PC values.
REQ-008 busy  output  1  SHALL be high in every state except IDLE.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 valM  output  64  SHALL hold the last read data.
REQ-011 mem_err  output  1  SHALL qualify done; high means the access failed.
REQ-012 req_valid, req_we  output  1 each; req_addr, req_wdata  output  64 each  SHALL form the request channel to data memory.
REQ-013 req_ready  input  1  SHALL accept a request when high together with req_valid.
REQ-014 rsp_valid, rsp_err  input  1 each; rsp_rdata  input  64  SHALL form the response channel; writes also receive a response (ack).

Function
REQ-015 Opcode map SHALL be:
- 4 rmmovq: write, address valE, data valA.
- 5 mrmovq: read, address valE.
- 8 call: write, address valE, data valP.
- 9 ret: read, address valA.
- A pushq: write, address valE, data valA.
- B popq: read, address valA.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch icode, address and write data.
REQ-018 From IDLE on start, a memory opcode with address < ADDR_LIMIT SHALL go to REQ.
REQ-019 From IDLE on start, any other opcode SHALL go to DONE with mem_err=0, no bus activity and valM unchanged.
REQ-020 From IDLE on start, a memory opcode with address >= ADDR_LIMIT SHALL go to DONE with mem_err=1 and no bus activity.
REQ-021 In REQ, req_valid SHALL be 1 and req_we/addr/wdata SHALL be stable until the cycle where req_ready=1; that cycle moves to WAIT.
REQ-022 In WAIT, req_valid SHALL be 0 and a cycle counter SHALL run.
REQ-023 In WAIT with rsp_valid=1, the block SHALL go to DONE with mem_err=rsp_err; for reads with rsp_err=0 it SHALL load valM=rsp_rdata.
REQ-024 If the WAIT counter reaches TIMEOUT with no rsp_valid, the block SHALL go to DONE with mem_err=1 and valM unchanged.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; mem_err SHALL hold until the next start.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 rsp_valid outside WAIT SHALL be ignored.
REQ-028 rsp_valid in the same cycle as the REQ handshake SHALL be ignored; a response counts only from WAIT.
REQ-029 Latency with req_ready=1 and rsp_valid one cycle after the handshake:
- start at cycle N, req_valid at N+1, rsp_valid at N+2, done at N+3.
- Non-memory or out-of-range opcode: done at N+1.
REQ-030 The timeout counter SHALL be 4 bits wide, cleared on entry to WAIT, and saturate; address compare SHALL be unsigned 64-bit.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with busy, done, mem_err and req_valid at 0 and req_we, req_addr, req_wdata, valM and the counter all-zero.
REQ-032 Reset asserted during REQ or WAIT SHALL abort the transaction with no done pulse.
REQ-033 A response arriving after such an abort SHALL be ignored.

Verification
REQ-034 mrmovq, valE=7, req_ready=1, rsp_rdata=5 one cycle later -> req_we=0, req_addr=7, done at N+3, valM=5, mem_err=0.
REQ-035 pushq, valE=100, valA=0x1234, req_ready low 3 cycles -> req_valid held with stable addr/data for 4 cycles, ack accepted, done with mem_err=0, valM unchanged.
REQ-036 ret, valA=2000 -> no req_valid, done at N+1, mem_err=1.
REQ-037 call, no response -> done after 15 WAIT cycles with mem_err=1; then a late rsp_valid in IDLE -> ignored.
REQ-038 icode=6, start=1 -> done at N+1, mem_err=0, no bus activity; a second start while busy -> ignored.
REQ-039 rst_n low during WAIT of popq -> all outputs 0 at once, no done pulse, subsequent rsp_valid ignored.
